fetch_stage: RTL and testbench

Parametrised instruction-fetch stage for the in-order pipeline. It owns the fetch PC, a synchronous-read instruction memory (IMEM) with a loader write port, and the IF/ID output register. It handles two-level redirection: EX redirects have priority over ID static-prediction redirects. It supports ID back-pressure (stall) and emits a valid qualifier so redirects create explicit bubbles.

---
 rtl/fetch_stage.sv | 145 ++++++++++++++
 tb/tb_fetch_stage.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage with fetch PC, synchronous-read IMEM
// (loader write port) and the IF/ID output register.
//
// Optional feature macro: FETCH_MISALIGN_CHECK_EN
//   defined   : misaligned redirect targets raise excMisalignF_o, present
//               NOP_INSTR and freeze fetch until the next EX redirect.
//   undefined : redirect targets are word-aligned (bits[1:0] cleared) and
//               excMisalignF_o is tied low.
//
// Ports:
//   clk, resetn                       clock / async active-low reset
//   stallD_i                          ID back-pressure, holds F outputs
//   takenE_i, redirectE_i             EX redirect (highest priority)
//   takenD_i, redirectD_i             ID static-prediction redirect
//   imemWe_i, imemWAddr_i, imemWData_i IMEM loader write port
//   validF_o, instructionF_o, pcF_o,
//   pcPlus4F_o, excMisalignF_o        registered IF/ID outputs
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_DEPTH = 1024,
    parameter int unsigned IMEM_AW    = $clog2(IMEM_DEPTH),
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               stallD_i,
    input  logic               takenE_i,
    input  logic [31:0]        redirectE_i,
    input  logic               takenD_i,
    input  logic [31:0]        redirectD_i,
    input  logic               imemWe_i,
    input  logic [IMEM_AW-1:0] imemWAddr_i,
    input  logic [31:0]        imemWData_i,
    output logic               validF_o,
    output logic [31:0]        instructionF_o,
    output logic [31:0]        pcF_o,
    output logic [31:0]        pcPlus4F_o,
    output logic               excMisalignF_o
);

    localparam int unsigned XLEN = 32;

    logic [XLEN-1:0] mem_q [IMEM_DEPTH];

    // pc_q is the address fetched at the next unstalled edge
    logic [XLEN-1:0] pc_q, pc_d;
    logic            valid_q, valid_d;
    logic [XLEN-1:0] pcf_q, pcf_d;
    logic [XLEN-1:0] pcp4_q, pcp4_d;
    logic            exc_q, exc_d;
    logic [XLEN-1:0] instr_q;
    logic            rd_en_c;
    logic            nop_en_c;
    logic            mis_c;
    logic [XLEN-1:0] tgt_e_c, tgt_d_c;
    logic [IMEM_AW-1:0] rd_idx_c;

    assign rd_idx_c = pc_q[IMEM_AW+1:2];

`ifdef FETCH_MISALIGN_CHECK_EN
    assign tgt_e_c = redirectE_i;
    assign tgt_d_c = redirectD_i;
    assign mis_c   = |pc_q[1:0];
    assign excMisalignF_o = exc_q;
`else
    assign tgt_e_c = redirectE_i & ~XLEN'(3);
    assign tgt_d_c = redirectD_i & ~XLEN'(3);
    assign mis_c   = 1'b0;
    assign excMisalignF_o = 1'b0;
`endif

    // Next-state selection: EX redirect > freeze > stall > ID redirect > sequential
    always_comb begin
        pc_d     = pc_q;
        valid_d  = valid_q;
        pcf_d    = pcf_q;
        pcp4_d   = pcp4_q;
        exc_d    = exc_q;
        rd_en_c  = 1'b0;
        nop_en_c = 1'b0;
        if (takenE_i) begin
            pc_d    = tgt_e_c;
            valid_d = 1'b0;
            exc_d   = 1'b0;
        end else if (exc_q || stallD_i) begin
            // frozen after a misalign exception, or held by ID
        end else if (takenD_i) begin
            pc_d    = tgt_d_c;
            valid_d = 1'b0;
        end else if (mis_c) begin
            valid_d  = 1'b1;
            exc_d    = 1'b1;
            pcf_d    = pc_q;
            pcp4_d   = XLEN'(pc_q + XLEN'(4));
            nop_en_c = 1'b1;
        end else begin
            valid_d = 1'b1;
            pcf_d   = pc_q;
            pcp4_d  = XLEN'(pc_q + XLEN'(4));
            pc_d    = XLEN'(pc_q + XLEN'(4));
            rd_en_c = 1'b1;
        end
    end

    // Fetch PC and IF/ID control registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pc_q    <= RESET_PC;
            valid_q <= 1'b0;
            pcf_q   <= RESET_PC;
            pcp4_q  <= XLEN'(RESET_PC + XLEN'(4));
            exc_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            valid_q <= valid_d;
            pcf_q   <= pcf_d;
            pcp4_q  <= pcp4_d;
            exc_q   <= exc_d;
        end
    end

    // Loader write port; array is not reset
    always_ff @(posedge clk) begin
        if (imemWe_i) begin
            mem_q[imemWAddr_i] <= imemWData_i;
        end
    end

    // Synchronous read doubles as the instruction output register (read-first)
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            instr_q <= '0;
        end else if (rd_en_c) begin
            instr_q <= mem_q[rd_idx_c];
        end else if (nop_en_c) begin
            instr_q <= NOP_INSTR;
        end
    end

    assign validF_o       = valid_q;
    assign instructionF_o = instr_q;
    assign pcF_o          = pcf_q;
    assign pcPlus4F_o     = pcp4_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: scoreboard bench for fetch_stage (IMEM_DEPTH=16 so that
// address wrap is exercised). Follows FETCH_MISALIGN_CHECK_EN like the RTL.
module tb_fetch_stage;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned AW    = 4;
    localparam logic [31:0] RPC   = 32'h0000_0000;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    typedef struct packed {
        logic        v;
        logic [31:0] pc;
        logic [31:0] ins;
        logic        exc;
    } exp_t;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          stallD_i = 1'b0;
    logic          takenE_i = 1'b0;
    logic [31:0]   redirectE_i = '0;
    logic          takenD_i = 1'b0;
    logic [31:0]   redirectD_i = '0;
    logic          imemWe_i = 1'b0;
    logic [AW-1:0] imemWAddr_i = '0;
    logic [31:0]   imemWData_i = '0;
    logic          validF_o;
    logic [31:0]   instructionF_o;
    logic [31:0]   pcF_o;
    logic [31:0]   pcPlus4F_o;
    logic          excMisalignF_o;

    fetch_stage #(
        .RESET_PC  (RPC),
        .IMEM_DEPTH(DEPTH),
        .NOP_INSTR (NOP)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .stallD_i      (stallD_i),
        .takenE_i      (takenE_i),
        .redirectE_i   (redirectE_i),
        .takenD_i      (takenD_i),
        .redirectD_i   (redirectD_i),
        .imemWe_i      (imemWe_i),
        .imemWAddr_i   (imemWAddr_i),
        .imemWData_i   (imemWData_i),
        .validF_o      (validF_o),
        .instructionF_o(instructionF_o),
        .pcF_o         (pcF_o),
        .pcPlus4F_o    (pcPlus4F_o),
        .excMisalignF_o(excMisalignF_o)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    logic [31:0] mm [DEPTH];
    logic [31:0] nxt;
    logic        frozen;
    exp_t        cur;
    exp_t        sb [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [31:0] align(input logic [31:0] t);
`ifdef FETCH_MISALIGN_CHECK_EN
        return t;
`else
        return t & 32'hFFFF_FFFC;
`endif
    endfunction

    function automatic logic misal(input logic [31:0] a);
`ifdef FETCH_MISALIGN_CHECK_EN
        return a[1:0] != 2'b00;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_reset();
        nxt    = RPC;
        frozen = 1'b0;
        cur    = '{v: 1'b0, pc: RPC, ins: 32'h0, exc: 1'b0};
        sb.delete();
    endtask

    // One clock: drive inputs, push expected outputs, then pop and compare
    task automatic step(input logic st, input logic te, input logic [31:0] re,
                        input logic td, input logic [31:0] rd,
                        input logic we, input logic [AW-1:0] wa, input logic [31:0] wd);
        exp_t e;
        exp_t o;
        logic [AW-1:0] ix;
        e = cur;
        if (te) begin
            nxt = align(re); e.v = 1'b0; e.exc = 1'b0; frozen = 1'b0;
        end else if (frozen || st) begin
            e = cur;
        end else if (td) begin
            nxt = align(rd); e.v = 1'b0;
        end else if (misal(nxt)) begin
            e.v = 1'b1; e.exc = 1'b1; e.pc = nxt; e.ins = NOP; frozen = 1'b1;
        end else begin
            ix = AW'(nxt >> 2);
            e.v = 1'b1; e.pc = nxt; e.ins = mm[ix];
            nxt = nxt + 32'd4;
        end
        if (we) mm[wa] = wd;
        cur = e;
        sb.push_back(e);
        stallD_i = st; takenE_i = te; redirectE_i = re;
        takenD_i = td; redirectD_i = rd;
        imemWe_i = we; imemWAddr_i = wa; imemWData_i = wd;
        @(posedge clk);
        #1;
        o = sb.pop_front();
        check("valid", 32'(validF_o), 32'(o.v));
        if (o.v) begin
            check("pc", pcF_o, o.pc);
            check("instr", instructionF_o, o.ins);
            check("pcplus4", pcPlus4F_o, o.pc + 32'd4);
        end
        check("exc", 32'(excMisalignF_o), 32'(o.exc));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, '0, 32'h0);
    endtask

    task automatic stall(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, '0, 32'h0);
    endtask

    task automatic check_reset_state();
        check("rst_valid", 32'(validF_o), 32'h0);
        check("rst_pc", pcF_o, RPC);
        check("rst_pcplus4", pcPlus4F_o, RPC + 32'd4);
        check("rst_instr", instructionF_o, 32'h0);
        check("rst_exc", 32'(excMisalignF_o), 32'h0);
    endtask

    initial begin
        model_reset();
        // Load mem[i] = i + 100 while in reset
        for (int i = 0; i < DEPTH; i++) begin
            imemWe_i = 1'b1; imemWAddr_i = AW'(i); imemWData_i = 32'(i + 100);
            mm[i] = 32'(i + 100);
            @(posedge clk);
            #1;
        end
        imemWe_i = 1'b0;
        check_reset_state();
        resetn = 1'b1;

        // Sequential fetch 0,4,8 then stall holding 8/102, release to 12/103
        run(3);
        stall(3);
        run(2);

        // ID redirect to 0x40 (wraps to word 0 at depth 16)
        step(1'b0, 1'b0, 32'h0, 1'b1, 32'h40, 1'b0, '0, 32'h0);
        run(3);

        // EX + ID redirect together while stalled: EX wins, bubble held by stall
        step(1'b1, 1'b1, 32'h80, 1'b1, 32'h40, 1'b0, '0, 32'h0);
        stall(2);
        run(2);
        // ID redirect alone while stalled has no effect
        step(1'b1, 1'b0, 32'h0, 1'b1, 32'h20, 1'b0, '0, 32'h0);
        step(1'b1, 1'b0, 32'h0, 1'b1, 32'h20, 1'b0, '0, 32'h0);
        run(2);

        // Loader write word 3, redirect to 0x4C (wraps to word 3)
        step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 4'd3, 32'hDEAD_BEEF);
        step(1'b0, 1'b0, 32'h0, 1'b1, 32'h4C, 1'b0, '0, 32'h0);
        run(2);

        // Write to the word fetched this edge: old value read, new value later
        step(1'b0, 1'b0, 32'h0, 1'b1, 32'h10, 1'b0, '0, 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 4'd4, 32'hCAFE_0004);
        step(1'b0, 1'b0, 32'h0, 1'b1, 32'h10, 1'b0, '0, 32'h0);
        run(2);

        // EX redirect in the bubble and in the following cycle: newest wins
        step(1'b0, 1'b0, 32'h0, 1'b1, 32'h20, 1'b0, '0, 32'h0);
        step(1'b0, 1'b1, 32'h30, 1'b0, 32'h0, 1'b0, '0, 32'h0);
        step(1'b0, 1'b1, 32'h34, 1'b0, 32'h0, 1'b0, '0, 32'h0);
        run(2);

        // PC wrap at 2^32
        step(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b0, 32'h0, 1'b0, '0, 32'h0);
        run(4);

        // Misaligned EX target, then ID redirect (ignored if frozen), then recover
        step(1'b0, 1'b1, 32'h102, 1'b0, 32'h0, 1'b0, '0, 32'h0);
        run(2);
        step(1'b0, 1'b0, 32'h0, 1'b1, 32'h40, 1'b0, '0, 32'h0);
        run(1);
        step(1'b0, 1'b1, 32'h200, 1'b0, 32'h0, 1'b0, '0, 32'h0);
        run(3);

        // Reset during a pending redirect discards the target
        step(1'b0, 1'b1, 32'h60, 1'b0, 32'h0, 1'b0, '0, 32'h0);
        #2;
        resetn = 1'b0;
        #1;
        check_reset_state();
        takenE_i = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        resetn = 1'b1;
        run(3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
